// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// default widths and the host/dump stream beat.
package data_mem_responder_pkg;

    localparam int DMR_DATA_W = 32;
    localparam int DMR_ADDR_W = 10;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2
    } st_e;

    typedef struct packed {
        logic [DMR_DATA_W-1:0] data;
        logic                  last;
    } dmr_beat_t;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word array with one write port, one asynchronous read port (processor loads)
// and one enabled, registered read port (host readback).
module dmr_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_b_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];

    // Output register only updates on a fetch, so a stalled beat stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_b_reg <= '0;
        end else if (re_b) begin
            rdata_b_reg <= mem[raddr_b];
        end
    end

    assign rdata_b = rdata_b_reg;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with host fill after reset and on-demand readback.
// Optional load/store counters are enabled by defining DMR_ACCESS_COUNT_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = DMR_DATA_W,
    parameter int ADDR_W = DMR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addressData,
    input  logic [DATA_W-1:0] storeData,
    input  logic              MWE,
    input  logic              MRE,
    output logic [DATA_W-1:0] loadedData,
    output logic              proc_hold,
    output logic              err_oob,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              dump_req,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    input  logic              dump_ready
`ifdef DMR_ACCESS_COUNT_EN
    ,
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    st_e               state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              dump_valid_reg, dump_valid_next;
    logic              dump_last_reg, dump_last_next;
    logic              err_oob_reg, err_oob_next;

    logic              ram_we, ram_re_b;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata, rdata_a, rdata_b;

    dmr_beat_t         host_beat;
    logic              in_range, run, ld_hit, st_hit;
    logic [ADDR_W-1:0] word_addr;

    assign host_beat = '{data: host_data, last: host_last};
    assign in_range  = (addressData[DATA_W-1:ADDR_W] == '0);
    assign word_addr = addressData[ADDR_W-1:0];
    assign run       = (state_reg == RUN);
    assign ld_hit    = run & MRE & in_range;
    assign st_hit    = run & MWE & in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LOAD;
            idx_reg        <= '0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
            err_oob_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            dump_valid_reg <= dump_valid_next;
            dump_last_reg  <= dump_last_next;
            err_oob_reg    <= err_oob_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        dump_valid_next = dump_valid_reg;
        dump_last_next  = dump_last_reg;
        err_oob_next    = err_oob_reg;
        ram_we          = 1'b0;
        ram_waddr       = idx_reg;
        ram_wdata       = host_beat.data;
        ram_re_b        = 1'b0;
        case (state_reg)
            LOAD: begin
                if (host_valid && host_ready) begin
                    ram_we   = 1'b1;
                    idx_next = idx_reg + 1'b1;
                    if (host_beat.last || idx_reg == LAST_IDX) begin
                        state_next = RUN;
                        idx_next   = '0;
                    end
                end
            end
            RUN: begin
                ram_we    = st_hit;
                ram_waddr = word_addr;
                ram_wdata = storeData;
                if ((MRE || MWE) && !in_range) begin
                    err_oob_next = 1'b1;
                end
                if (dump_req) begin
                    state_next = DUMP;
                    idx_next   = '0;
                end
            end
            DUMP: begin
                // Fetch the next word whenever the output slot is empty or being
                // drained, until the final word has been fetched.
                if (!dump_valid_reg || (dump_ready && !dump_last_reg)) begin
                    ram_re_b        = 1'b1;
                    idx_next        = idx_reg + 1'b1;
                    dump_valid_next = 1'b1;
                    dump_last_next  = (idx_reg == LAST_IDX);
                end else if (dump_ready) begin
                    dump_valid_next = 1'b0;
                    dump_last_next  = 1'b0;
                    state_next      = RUN;
                    idx_next        = '0;
                end
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
    end

    dmr_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr_a(word_addr),
        .rdata_a(rdata_a),
        .re_b   (ram_re_b),
        .raddr_b(idx_reg),
        .rdata_b(rdata_b)
    );

    assign loadedData = ld_hit ? rdata_a : '0;
    assign proc_hold  = (state_reg != RUN);
    assign host_ready = (state_reg == LOAD) & ~rst;
    assign err_oob    = err_oob_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_last  = dump_last_reg;
    assign dump_data  = rdata_b;

`ifdef DMR_ACCESS_COUNT_EN
    logic [1:0] cnt_inc;
    assign cnt_inc = {st_hit, ld_hit};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign ld_count = g_cnt[0].cnt_reg;
    assign st_count = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: fill, load/store, out-of-range,
// paced readback and reset during readback.
module tb_data_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] addressData = '0;
    logic [DW-1:0] storeData = '0;
    logic          MWE = 1'b0;
    logic          MRE = 1'b0;
    logic [DW-1:0] loadedData;
    logic          proc_hold;
    logic          err_oob;
    logic          host_valid = 1'b0;
    logic [DW-1:0] host_data = '0;
    logic          host_last = 1'b0;
    logic          host_ready;
    logic          dump_req = 1'b0;
    logic          dump_valid;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          dump_ready = 1'b0;
`ifdef DMR_ACCESS_COUNT_EN
    logic [31:0]   ld_count;
    logic [31:0]   st_count;
`endif

    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addressData(addressData),
        .storeData  (storeData),
        .MWE        (MWE),
        .MRE        (MRE),
        .loadedData (loadedData),
        .proc_hold  (proc_hold),
        .err_oob    (err_oob),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .dump_req   (dump_req),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_ready (dump_ready)
`ifdef DMR_ACCESS_COUNT_EN
        ,
        .ld_count   (ld_count),
        .st_count   (st_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (proc_hold !== 1'b1) begin n_fail++; $display("FAIL reset_proc_hold: got %b expected 1", proc_hold); end
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL reset_host_ready: got %b expected 0", host_ready); end
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob: got %b expected 0", err_oob); end
        n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid: got %b expected 0", dump_valid); end
        n_checks++; if (dump_data !== 32'h0) begin n_fail++; $display("FAIL reset_dump_data: got %h expected 0", dump_data); end
        n_checks++; if (dump_last !== 1'b0) begin n_fail++; $display("FAIL reset_dump_last: got %b expected 0", dump_last); end
        n_checks++; if (loadedData !== 32'h0) begin n_fail++; $display("FAIL reset_loadedData: got %h expected 0", loadedData); end
        rst = 1'b0;
        #1;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL load_host_ready: got %b expected 1", host_ready); end
        $display("test_reset done");
    endtask

    task automatic test_fill_short;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = 32'hA0 + i;
            host_last  = (i == 3);
            model[i]   = 32'hA0 + i;
            tick();
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        n_checks++; if (proc_hold !== 1'b0) begin n_fail++; $display("FAIL short_fill_proc_hold: got %b expected 0", proc_hold); end
        MRE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addressData = i;
            #1;
            n_checks++; if (loadedData !== 32'hA0 + i) begin n_fail++; $display("FAIL short_fill_load[%0d]: got %h expected %h", i, loadedData, 32'hA0 + i); end
        end
        MRE = 1'b0;
        $display("test_fill_short done");
    endtask

    task automatic test_fill_full;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            host_valid = 1'b1;
            host_data  = 32'h5500_0000 | i;
            host_last  = 1'b0;
            model[i]   = 32'h5500_0000 | i;
            if (i == DEPTH - 1) begin
                #1;
                n_checks++; if (proc_hold !== 1'b1 || host_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_before_last: got hold=%b ready=%b expected hold=1 ready=1", proc_hold, host_ready); end
            end
            tick();
        end
        // Keep offering a word after the fill completes; it must be ignored.
        host_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (proc_hold !== 1'b0) begin n_fail++; $display("FAIL full_fill_proc_hold: got %b expected 0", proc_hold); end
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_fill_host_ready: got %b expected 0", host_ready); end
        tick();
        host_valid = 1'b0;
        MRE = 1'b1;
        addressData = 0;
        #1;
        n_checks++; if (loadedData !== 32'h5500_0000) begin n_fail++; $display("FAIL full_fill_idx0: got %h expected 55000000", loadedData); end
        addressData = DEPTH - 1;
        #1;
        n_checks++; if (loadedData !== 32'h5500_03FF) begin n_fail++; $display("FAIL full_fill_idx_last: got %h expected 550003ff", loadedData); end
        MRE = 1'b0;
        #1;
        n_checks++; if (loadedData !== 32'h0) begin n_fail++; $display("FAIL no_mre_zero: got %h expected 0", loadedData); end
        $display("test_fill_full done");
    endtask

    task automatic test_store;
        addressData = 5;
        storeData   = 32'hDEAD;
        MWE = 1'b1;
        tick();
        MWE = 1'b0;
        MRE = 1'b1;
        #1;
        n_checks++; if (loadedData !== 32'hDEAD) begin n_fail++; $display("FAIL store_then_load: got %h expected 0000dead", loadedData); end
        storeData = 32'hBEEF;
        MWE = 1'b1;
        #1;
        n_checks++; if (loadedData !== 32'hDEAD) begin n_fail++; $display("FAIL rw_same_cycle_old: got %h expected 0000dead", loadedData); end
        tick();
        MWE = 1'b0;
        #1;
        n_checks++; if (loadedData !== 32'hBEEF) begin n_fail++; $display("FAIL rw_same_cycle_commit: got %h expected 0000beef", loadedData); end
        MRE = 1'b0;
        model[5] = 32'hBEEF;
        $display("test_store done");
    endtask

    task automatic test_oob;
        n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_before: got %b expected 0", err_oob); end
        addressData = 32'h0000_0400;
        MRE = 1'b1;
        #1;
        n_checks++; if (loadedData !== 32'h0) begin n_fail++; $display("FAIL oob_load: got %h expected 0", loadedData); end
        tick();
        MRE = 1'b0;
        n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_err_set: got %b expected 1", err_oob); end
        storeData = 32'h1234;
        MWE = 1'b1;
        tick();
        MWE = 1'b0;
        addressData = 0;
        MRE = 1'b1;
        tick();
        tick();
        n_checks++; if (loadedData !== model[0]) begin n_fail++; $display("FAIL oob_store_dropped: got %h expected %h", loadedData, model[0]); end
        n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_err_sticky: got %b expected 1", err_oob); end
        MRE = 1'b0;
        $display("test_oob done");
    endtask

    task automatic test_dump;
        int k;
        logic prev_hold;
        logic [DW-1:0] prev_data;
        k = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        n_checks++; if (proc_hold !== 1'b1) begin n_fail++; $display("FAIL dump_proc_hold: got %b expected 1", proc_hold); end
        for (int cyc = 0; cyc < 6000 && k < DEPTH; cyc++) begin
            dump_ready = cyc[0];
            #1;
            if (dump_valid) begin
                n_checks++; if (dump_data !== model[k]) begin n_fail++; $display("FAIL dump_data[%0d]: got %h expected %h", k, dump_data, model[k]); end
                n_checks++; if (dump_last !== (k == DEPTH - 1)) begin n_fail++; $display("FAIL dump_last[%0d]: got %b expected %b", k, dump_last, (k == DEPTH - 1)); end
                if (prev_hold) begin
                    n_checks++; if (dump_data !== prev_data) begin n_fail++; $display("FAIL dump_hold[%0d]: got %h expected %h", k, dump_data, prev_data); end
                end
                prev_hold = !dump_ready;
                prev_data = dump_data;
                if (dump_ready) k++;
            end else begin
                prev_hold = 1'b0;
            end
            tick();
        end
        dump_ready = 1'b0;
        n_checks++; if (k != DEPTH) begin n_fail++; $display("FAIL dump_count: got %0d expected %0d", k, DEPTH); end
        #1;
        n_checks++; if (dump_valid !== 1'b0 || proc_hold !== 1'b0) begin n_fail++; $display("FAIL dump_exit: got valid=%b hold=%b expected valid=0 hold=0", dump_valid, proc_hold); end
        $display("test_dump done, %0d words", k);
    endtask

    task automatic test_reset_mid_dump;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        dump_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL mid_dump_valid: got %b expected 1", dump_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (dump_valid !== 1'b0 || proc_hold !== 1'b1 || dump_data !== 32'h0) begin n_fail++; $display("FAIL mid_dump_reset: got valid=%b hold=%b data=%h expected 0 1 0", dump_valid, proc_hold, dump_data); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (host_ready !== 1'b1 || proc_hold !== 1'b1) begin n_fail++; $display("FAIL mid_dump_to_load: got ready=%b hold=%b expected 1 1", host_ready, proc_hold); end
        $display("test_reset_mid_dump done");
    endtask

`ifdef DMR_ACCESS_COUNT_EN
    task automatic test_counts;
        host_valid = 1'b1;
        host_data  = 32'h77;
        host_last  = 1'b1;
        tick();
        host_valid = 1'b0;
        host_last  = 1'b0;
        n_checks++; if (ld_count !== 32'd0 || st_count !== 32'd0) begin n_fail++; $display("FAIL count_start: got ld=%0d st=%0d expected 0 0", ld_count, st_count); end
        addressData = 0;
        MRE = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        MRE = 1'b0;
        addressData = 1;
        MWE = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        MWE = 1'b0;
        addressData = 32'h0000_0400;
        MRE = 1'b1;
        tick();
        MRE = 1'b0;
        n_checks++; if (ld_count !== 32'd3) begin n_fail++; $display("FAIL ld_count: got %0d expected 3", ld_count); end
        n_checks++; if (st_count !== 32'd2) begin n_fail++; $display("FAIL st_count: got %0d expected 2", st_count); end
        $display("test_counts done");
    endtask
`endif

    initial begin
        test_reset();
        test_fill_short();
        test_fill_full();
        test_store();
        test_oob();
        test_dump();
        test_reset_mid_dump();
`ifdef DMR_ACCESS_COUNT_EN
        test_counts();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
